// File: rtl/piece_drop_ctrl.sv
// Falling-piece sequencer: owns the active piece, runs gravity, arbitrates player
// commands and sequences the collision-check, draw/erase and lock handshakes.
module piece_drop_ctrl #(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned BOARD_H    = 20,
   parameter int unsigned X_BITS     = 5,
   parameter int unsigned Y_BITS     = 6,
   parameter int unsigned DROP_TICKS = 25000000,
   parameter int unsigned SPAWN_X    = 4,
   parameter int unsigned SPAWN_Y    = 0,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              rotate,
   input  logic              soft_drop,
   output logic [X_BITS-1:0] anc_x,
   output logic [Y_BITS-1:0] anc_y,
   output logic [2:0]        piece,
   output logic [1:0]        rot,
   output logic [X_BITS-1:0] cand_x,
   output logic [Y_BITS-1:0] cand_y,
   output logic [1:0]        cand_rot,
   output logic              chk_req,
   input  logic              chk_done,
   input  logic              chk_hit,
   output logic              draw_req,
   output logic              draw_erase,
   output logic [X_BITS-1:0] draw_x,
   output logic [Y_BITS-1:0] draw_y,
   output logic [1:0]        draw_rot,
   input  logic              draw_done,
   output logic              lock_req,
   input  logic              lock_done,
   output logic              game_over
);

   localparam int unsigned       CNT_W     = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(DROP_TICKS - 1);
   localparam logic [X_BITS-1:0] X_SPAWN   = X_BITS'(SPAWN_X);
   localparam logic [X_BITS-1:0] X_MAX     = X_BITS'(BOARD_W - 1);
   localparam logic [Y_BITS-1:0] Y_SPAWN   = Y_BITS'(SPAWN_Y);
   localparam logic [Y_BITS-1:0] Y_MAX     = Y_BITS'(BOARD_H - 1);
   localparam int unsigned P_RIGHT = 0;
   localparam int unsigned P_LEFT  = 1;
   localparam int unsigned P_ROT   = 2;
   localparam int unsigned P_DROP  = 3;

   typedef enum logic [3:0] {
      S_IDLE, S_SPAWN, S_SPAWN_CHK, S_PLAY, S_CHK, S_ERASE, S_DRAW, S_LOCK, S_OVER
   } state_t;

   state_t            r_state, w_next;
   logic [X_BITS-1:0] r_anc_x, w_anc_x, r_cand_x, w_cand_x, r_draw_x, w_draw_x;
   logic [Y_BITS-1:0] r_anc_y, w_anc_y, r_cand_y, w_cand_y, r_draw_y, w_draw_y;
   logic [1:0]        r_rot, w_rot, r_cand_rot, w_cand_rot, r_draw_rot, w_draw_rot;
   logic [2:0]        r_piece, w_piece;
   logic [3:0]        r_pend, w_pend, w_set;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic [7:0]        r_lfsr, w_lfsr;
   logic              r_cmd_drop, w_cmd_drop;
   logic              r_chk_req, w_chk_req, r_draw_req, w_draw_req, r_draw_erase, w_draw_erase;
   logic              r_lock_req, w_lock_req, r_game_over, w_game_over;
   logic              w_active, w_tick, w_chk_ok, w_draw_ok, w_lock_ok;

   assign w_chk_ok  = r_chk_req & chk_done;
   assign w_draw_ok = r_draw_req & draw_done;
   assign w_lock_ok = r_lock_req & lock_done;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_anc_x      = r_anc_x;
      w_anc_y      = r_anc_y;
      w_rot        = r_rot;
      w_piece      = r_piece;
      w_cand_x     = r_cand_x;
      w_cand_y     = r_cand_y;
      w_cand_rot   = r_cand_rot;
      w_draw_x     = r_draw_x;
      w_draw_y     = r_draw_y;
      w_draw_rot   = r_draw_rot;
      w_lfsr       = r_lfsr;
      w_cmd_drop   = r_cmd_drop;
      w_cnt        = r_cnt;
      w_pend       = r_pend;
      w_active     = (r_state != S_IDLE) && (r_state != S_OVER);
      w_tick       = w_active && (r_cnt == TICK_LAST);
      w_set        = {soft_drop | w_tick, rotate, move_left, move_right};
      if (w_active) begin
         w_cnt  = w_tick ? '0 : r_cnt + 1'b1;
         w_pend = r_pend | w_set;
      end

      case (r_state)
         S_IDLE: if (go) w_next = S_SPAWN;
         S_SPAWN: begin
            w_piece    = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];
            w_anc_x    = X_SPAWN;
            w_anc_y    = Y_SPAWN;
            w_rot      = 2'd0;
            w_cand_x   = X_SPAWN;
            w_cand_y   = Y_SPAWN;
            w_cand_rot = 2'd0;
            w_lfsr     = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            w_cnt      = '0;
            w_pend     = '0;
            w_next     = S_SPAWN_CHK;
         end
         S_SPAWN_CHK: if (w_chk_ok) w_next = chk_hit ? S_OVER : S_DRAW;
         S_PLAY: begin
            // Selection uses only bits already pending; this cycle's pulses queue behind.
            if (r_pend[P_DROP]) begin
               w_pend[P_DROP] = 1'b0;
               if (r_anc_y == Y_MAX) begin
                  w_next = S_LOCK;
               end else begin
                  w_cand_x   = r_anc_x;
                  w_cand_y   = r_anc_y + 1'b1;
                  w_cand_rot = r_rot;
                  w_cmd_drop = 1'b1;
                  w_next     = S_CHK;
               end
            end else if (r_pend[P_ROT]) begin
               w_pend[P_ROT] = 1'b0;
               w_cand_x      = r_anc_x;
               w_cand_y      = r_anc_y;
               w_cand_rot    = r_rot + 2'd1;
               w_cmd_drop    = 1'b0;
               w_next        = S_CHK;
            end else if (r_pend[P_LEFT]) begin
               w_pend[P_LEFT] = 1'b0;
               if (r_anc_x != '0) begin
                  w_cand_x   = r_anc_x - 1'b1;
                  w_cand_y   = r_anc_y;
                  w_cand_rot = r_rot;
                  w_cmd_drop = 1'b0;
                  w_next     = S_CHK;
               end
            end else if (r_pend[P_RIGHT]) begin
               w_pend[P_RIGHT] = 1'b0;
               if (r_anc_x != X_MAX) begin
                  w_cand_x   = r_anc_x + 1'b1;
                  w_cand_y   = r_anc_y;
                  w_cand_rot = r_rot;
                  w_cmd_drop = 1'b0;
                  w_next     = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (w_chk_ok) begin
               if (chk_hit) w_next = r_cmd_drop ? S_LOCK : S_PLAY;
               else         w_next = S_ERASE;
            end
         end
         S_ERASE: if (w_draw_ok) w_next = S_DRAW;
         S_DRAW: begin
            if (w_draw_ok) begin
               w_anc_x = r_cand_x;
               w_anc_y = r_cand_y;
               w_rot   = r_cand_rot;
               w_next  = S_PLAY;
            end
         end
         S_LOCK: if (w_lock_ok) w_next = S_SPAWN;
         S_OVER: w_next = S_OVER;
         default: w_next = S_IDLE;
      endcase

      if (w_next == S_ERASE) begin
         w_draw_x   = r_anc_x;
         w_draw_y   = r_anc_y;
         w_draw_rot = r_rot;
      end else if (w_next == S_DRAW) begin
         w_draw_x   = r_cand_x;
         w_draw_y   = r_cand_y;
         w_draw_rot = r_cand_rot;
      end
      // ERASE->DRAW keeps draw_req low for one cycle so the accepted done is never re-read.
      w_chk_req    = (w_next == S_SPAWN_CHK) || (w_next == S_CHK);
      w_draw_req   = ((w_next == S_ERASE) || (w_next == S_DRAW)) && !w_draw_ok;
      w_draw_erase = (w_next == S_ERASE);
      w_lock_req   = (w_next == S_LOCK);
      w_game_over  = (w_next == S_OVER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_anc_x      <= X_SPAWN;
         r_anc_y      <= Y_SPAWN;
         r_rot        <= '0;
         r_piece      <= '0;
         r_cand_x     <= X_SPAWN;
         r_cand_y     <= Y_SPAWN;
         r_cand_rot   <= '0;
         r_draw_x     <= '0;
         r_draw_y     <= '0;
         r_draw_rot   <= '0;
         r_lfsr       <= LFSR_SEED;
         r_cmd_drop   <= 1'b0;
         r_cnt        <= '0;
         r_pend       <= '0;
         r_chk_req    <= 1'b0;
         r_draw_req   <= 1'b0;
         r_draw_erase <= 1'b0;
         r_lock_req   <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_anc_x      <= w_anc_x;
         r_anc_y      <= w_anc_y;
         r_rot        <= w_rot;
         r_piece      <= w_piece;
         r_cand_x     <= w_cand_x;
         r_cand_y     <= w_cand_y;
         r_cand_rot   <= w_cand_rot;
         r_draw_x     <= w_draw_x;
         r_draw_y     <= w_draw_y;
         r_draw_rot   <= w_draw_rot;
         r_lfsr       <= w_lfsr;
         r_cmd_drop   <= w_cmd_drop;
         r_cnt        <= w_cnt;
         r_pend       <= w_pend;
         r_chk_req    <= w_chk_req;
         r_draw_req   <= w_draw_req;
         r_draw_erase <= w_draw_erase;
         r_lock_req   <= w_lock_req;
         r_game_over  <= w_game_over;
      end
   end

   assign anc_x      = r_anc_x;
   assign anc_y      = r_anc_y;
   assign rot        = r_rot;
   assign piece      = r_piece;
   assign cand_x     = r_cand_x;
   assign cand_y     = r_cand_y;
   assign cand_rot   = r_cand_rot;
   assign chk_req    = r_chk_req;
   assign draw_req   = r_draw_req;
   assign draw_erase = r_draw_erase;
   assign draw_x     = r_draw_x;
   assign draw_y     = r_draw_y;
   assign draw_rot   = r_draw_rot;
   assign lock_req   = r_lock_req;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Scoreboard bench for piece_drop_ctrl: expected handshakes are queued ahead of the
// stimulus; a responder/monitor pops one per request and answers done/hit from it.
module tb_piece_drop_ctrl;
   localparam int unsigned DT = 64;

   logic       clk = 1'b0, reset = 1'b1, go = 1'b0;
   logic       move_left = 1'b0, move_right = 1'b0, rotate = 1'b0, soft_drop = 1'b0;
   logic       chk_done = 1'b0, chk_hit = 1'b0, draw_done = 1'b0, lock_done = 1'b0;
   logic [4:0] anc_x, cand_x, draw_x;
   logic [5:0] anc_y, cand_y, draw_y;
   logic [2:0] piece;
   logic [1:0] rot, cand_rot, draw_rot;
   logic       chk_req, draw_req, draw_erase, lock_req, game_over;

   piece_drop_ctrl #(.DROP_TICKS(DT)) dut (
      .clk(clk), .reset(reset), .go(go),
      .move_left(move_left), .move_right(move_right), .rotate(rotate), .soft_drop(soft_drop),
      .anc_x(anc_x), .anc_y(anc_y), .piece(piece), .rot(rot),
      .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
      .chk_req(chk_req), .chk_done(chk_done), .chk_hit(chk_hit),
      .draw_req(draw_req), .draw_erase(draw_erase), .draw_x(draw_x), .draw_y(draw_y),
      .draw_rot(draw_rot), .draw_done(draw_done),
      .lock_req(lock_req), .lock_done(lock_done), .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {K_CHK, K_ERASE, K_DRAW, K_LOCK} kind_t;
   typedef struct packed {
      kind_t      k;
      logic [4:0] x;
      logic [5:0] y;
      logic [1:0] r;
      logic       hit;
   } txn_t;

   txn_t  sb[$];
   int    chk_t[$];
   int    n_vec = 0, n_bad = 0, cyc = 0, rs = 0;
   bit    rec_on = 1'b0;
   kind_t cur_k = K_CHK;
   logic  cur_hit = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input kind_t k, input int x, input int y, input int r, input bit hit);
      txn_t t;
      t.k = k; t.x = 5'(x); t.y = 6'(y); t.r = 2'(r); t.hit = hit;
      sb.push_back(t);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic l, input logic r, input logic ro, input logic d, input logic g);
      @(negedge clk);
      move_left = l; move_right = r; rotate = ro; soft_drop = d; go = g;
      @(negedge clk);
      move_left = 0; move_right = 0; rotate = 0; soft_drop = 0; go = 0;
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while ((sb.size() != 0 || rs != 0 || chk_req || draw_req || lock_req) && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      n_vec++;
      if (n >= bound) begin
         n_bad++;
         $display("FAIL drain_%s: got %0d still queued after %0d cycles, expected 0", name, sb.size(), bound);
      end
      cycles(2);
   endtask

   // Responder/monitor: pick up a new request, compare, answer a cycle later, then expect release.
   initial begin
      txn_t       e;
      kind_t      ak;
      logic [4:0] ax;
      logic [5:0] ay;
      logic [1:0] ar;
      logic       still;
      forever begin
         @(negedge clk);
         if (reset) begin
            rs = 0; chk_done = 0; draw_done = 0; lock_done = 0; chk_hit = 0;
         end else begin
            case (rs)
               0: if (chk_req || draw_req || lock_req) begin
                  if (chk_req) begin
                     ak = K_CHK; ax = cand_x; ay = cand_y; ar = cand_rot;
                  end else if (lock_req) begin
                     ak = K_LOCK; ax = anc_x; ay = anc_y; ar = rot;
                  end else begin
                     ak = draw_erase ? K_ERASE : K_DRAW; ax = draw_x; ay = draw_y; ar = draw_rot;
                  end
                  cur_k = ak;
                  n_vec++;
                  if (sb.size() == 0) begin
                     n_bad++;
                     cur_hit = 1'b0;
                     $display("FAIL unexpected_req: got kind %0d at (%0d,%0d) rot %0d, expected no request",
                              ak, ax, ay, ar);
                  end else begin
                     e = sb.pop_front();
                     cur_hit = e.hit;
                     if ({ak, ax, ay, ar} != {e.k, e.x, e.y, e.r}) begin
                        n_bad++;
                        $display("FAIL txn: got kind %0d at (%0d,%0d) rot %0d, expected kind %0d at (%0d,%0d) rot %0d",
                                 ak, ax, ay, ar, e.k, e.x, e.y, e.r);
                     end
                     if (rec_on && ak == K_CHK) chk_t.push_back(cyc);
                  end
                  rs = 1;
               end
               1: begin
                  case (cur_k)
                     K_CHK:   begin chk_done = 1; chk_hit = cur_hit; end
                     K_LOCK:  lock_done = 1;
                     default: draw_done = 1;
                  endcase
                  rs = 2;
               end
               default: begin
                  chk_done = 0; draw_done = 0; lock_done = 0; chk_hit = 0;
                  still = (cur_k == K_CHK) ? chk_req : (cur_k == K_LOCK) ? lock_req : draw_req;
                  n_vec++;
                  if (still) begin
                     n_bad++;
                     $display("FAIL req_release: got req 1 after done for kind %0d, expected 0", cur_k);
                  end
                  rs = 0;
               end
            endcase
         end
      end
   end

   initial begin
      int n;
      cycles(2);
      check("reset_reqs", {chk_req, draw_req, lock_req, draw_erase, game_over}, 0);
      check("reset_anc", {anc_x, anc_y}, {5'd4, 6'd0});
      check("reset_cand", {cand_x, cand_y, cand_rot}, {5'd4, 6'd0, 2'd0});
      check("reset_piece_rot", {piece, rot}, 0);
      check("reset_draw", {draw_x, draw_y, draw_rot}, 0);
      @(negedge clk) reset = 0;

      // Spawn: seed A5 -> piece 5
      push(K_CHK, 4, 0, 0, 0); push(K_DRAW, 4, 0, 0, 0);
      pulse(0, 0, 0, 0, 1);
      drain("spawn", 100);
      check("spawn_piece", piece, 5);
      check("spawn_anc", {anc_x, anc_y, rot}, {5'd4, 6'd0, 2'd0});

      // Simultaneous rotate/left/soft_drop: served drop, rotate, left
      push(K_CHK, 4, 1, 0, 0); push(K_ERASE, 4, 0, 0, 0); push(K_DRAW, 4, 1, 0, 0);
      push(K_CHK, 4, 1, 1, 0); push(K_ERASE, 4, 1, 0, 0); push(K_DRAW, 4, 1, 1, 0);
      push(K_CHK, 3, 1, 1, 0); push(K_ERASE, 4, 1, 1, 0); push(K_DRAW, 3, 1, 1, 0);
      pulse(1, 0, 1, 1, 0);
      drain("multi", 200);
      check("multi_anc", {anc_x, anc_y, rot}, {5'd3, 6'd1, 2'd1});

      // Gravity drop
      push(K_CHK, 3, 2, 1, 0); push(K_ERASE, 3, 1, 1, 0); push(K_DRAW, 3, 2, 1, 0);
      drain("grav1", 200);
      check("grav1_y", anc_y, 2);

      // Two back-to-back rotate pulses collapse into one rotation
      push(K_CHK, 3, 2, 2, 0); push(K_ERASE, 3, 2, 1, 0); push(K_DRAW, 3, 2, 2, 0);
      @(negedge clk) rotate = 1;
      @(negedge clk);
      @(negedge clk) rotate = 0;
      drain("rot_absorb", 100);
      check("rot_absorb", rot, 2);
      push(K_CHK, 3, 2, 3, 0); push(K_ERASE, 3, 2, 2, 0); push(K_DRAW, 3, 2, 3, 0);
      pulse(0, 0, 1, 0, 0);
      drain("rot3", 100);
      push(K_CHK, 3, 2, 0, 0); push(K_ERASE, 3, 2, 3, 0); push(K_DRAW, 3, 2, 0, 0);
      pulse(0, 0, 1, 0, 0);
      drain("rot_wrap", 100);
      check("rot_wrap", rot, 0);

      push(K_CHK, 3, 3, 0, 0); push(K_ERASE, 3, 2, 0, 0); push(K_DRAW, 3, 3, 0, 0);
      drain("grav2", 200);

      for (int i = 0; i < 3; i++) begin
         push(K_CHK, 2 - i, 3, 0, 0); push(K_ERASE, 3 - i, 3, 0, 0); push(K_DRAW, 2 - i, 3, 0, 0);
         pulse(1, 0, 0, 0, 0);
         drain("left", 100);
      end
      check("left_x", anc_x, 0);

      push(K_CHK, 0, 4, 0, 0); push(K_ERASE, 0, 3, 0, 0); push(K_DRAW, 0, 4, 0, 0);
      drain("grav3", 200);

      // Left wall: rejected without a check
      pulse(1, 0, 0, 0, 0);
      cycles(6);
      check("left_wall", {anc_x, anc_y}, {5'd0, 6'd4});
      // Right with hit: candidate discarded, no draw
      push(K_CHK, 1, 4, 0, 1);
      pulse(0, 1, 0, 0, 0);
      drain("right_hit", 100);
      check("right_hit", {anc_x, anc_y, rot}, {5'd0, 6'd4, 2'd0});
      // Drop with hit locks, then the next spawn uses the advanced LFSR (4A -> piece 2)
      push(K_CHK, 0, 5, 0, 1); push(K_LOCK, 0, 4, 0, 0);
      push(K_CHK, 4, 0, 0, 0); push(K_DRAW, 4, 0, 0, 0);
      pulse(0, 0, 0, 1, 0);
      drain("drop_hit", 100);
      check("spawn2_piece", piece, 2);

      // Free fall to the floor; lock at y=19; next spawn (LFSR 95 -> piece 5) collides
      rec_on = 1'b1;
      for (int y = 1; y <= 19; y++) begin
         push(K_CHK, 4, y, 0, 0); push(K_ERASE, 4, y - 1, 0, 0); push(K_DRAW, 4, y, 0, 0);
      end
      push(K_LOCK, 4, 19, 0, 0);
      push(K_CHK, 4, 0, 0, 1);
      n = 0;
      while (!game_over && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      rec_on = 1'b0;
      check("game_over_set", game_over, 1);
      check("fall_queue_left", sb.size(), 0);
      check("over_piece", piece, 5);
      check("fall_chk_count", chk_t.size(), 20);
      for (int i = 1; i < 19 && i < chk_t.size(); i++)
         check("drop_interval", chk_t[i] - chk_t[i - 1], DT);

      pulse(0, 0, 0, 0, 1);
      pulse(1, 1, 1, 1, 1);
      cycles(5);
      check("over_sticky", {game_over, chk_req, draw_req, lock_req}, 4'b1000);

      @(negedge clk) reset = 1;
      @(negedge clk) reset = 0;
      #1;
      check("post_reset", {game_over, chk_req, draw_req, lock_req, piece}, 0);
      check("post_reset_anc", {anc_x, anc_y}, {5'd4, 6'd0});
      pulse(1, 1, 1, 1, 0);
      cycles(4);
      check("idle_ignores_cmds", {chk_req, draw_req, lock_req, draw_erase}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
